// File: rtl/pdm_pkg.sv
// Shared PDM definitions: PCM sample type, bit-clock period helper and the
// signed-to-offset-binary mapping used by the modulator and the receive path.
package pdm_pkg;

    localparam int PCM_WIDTH = 16;

    typedef logic signed [PCM_WIDTH-1:0] pcm_t;
    typedef logic        [PCM_WIDTH-1:0] ubin_t;

    localparam ubin_t SIGN_FLIP = {1'b1, {(PCM_WIDTH-1){1'b0}}};

    function automatic int pdm_period(input int clk_freq, input int pdm_freq);
        return clk_freq / pdm_freq;
    endfunction

    // Full scale negative maps to 0, zero maps to mid-scale.
    function automatic ubin_t to_offset_binary(input pcm_t s);
        return ubin_t'(s) ^ SIGN_FLIP;
    endfunction

endpackage

// File: rtl/pdm_clk_gen.sv
// PDM bit-clock divider: registered pdm_clk (high for the first half period)
// and a bit tick flagging the clk in which pdm_clk is registered high-to-low.
module pdm_clk_gen
    import pdm_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int PDM_CLK_FREQ = 3_072_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic enable_i,
    output logic pdm_clk_o,
    output logic bit_tick_o
);

    localparam int PERIOD = pdm_period(CLK_FREQ, PDM_CLK_FREQ);
    localparam int H      = PERIOD / 2;
    localparam int CNT_W  = (PERIOD > 2) ? $clog2(PERIOD) : 1;

    generate
        if (PERIOD < 2) begin : g_bad_period
            $error("pdm_clk_gen: CLK_FREQ/PDM_CLK_FREQ must be at least 2");
        end
    endgenerate

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pdm_clk_q, pdm_clk_d;

    always_comb begin
        cnt_d     = '0;
        pdm_clk_d = 1'b0;
        if (enable_i) begin
            cnt_d     = (cnt_q == CNT_W'(PERIOD - 1)) ? '0 : cnt_q + 1'b1;
            pdm_clk_d = (cnt_q < CNT_W'(H));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            pdm_clk_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pdm_clk_q <= pdm_clk_d;
        end
    end

    // Gated by enable so that a disable while pdm_clk is high is not a tick.
    assign bit_tick_o = enable_i & pdm_clk_q & ~pdm_clk_d;
    assign pdm_clk_o  = pdm_clk_q;

endmodule

// File: rtl/pdm_modulator.sv
// PCM-to-PDM transmitter: one-entry sample buffer behind valid/ready, a
// first-order carry-out modulator clocked by the bit tick, OSR bits per sample.
module pdm_modulator
    import pdm_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int PDM_CLK_FREQ = 3_072_000,
    parameter int OSR          = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [PCM_WIDTH-1:0] pcm_in,
    input  logic                 pcm_valid,
    output logic                 pcm_ready,
    output logic                 pdm_clk,
    output logic                 pdm_data,
    output logic                 underrun
);

    localparam int WIN_W = (OSR > 1) ? $clog2(OSR) : 1;

    generate
        if (OSR < 1) begin : g_bad_osr
            $error("pdm_modulator: OSR must be at least 1");
        end
    endgenerate

    logic bit_tick;

    pdm_clk_gen #(
        .CLK_FREQ     (CLK_FREQ),
        .PDM_CLK_FREQ (PDM_CLK_FREQ)
    ) u_clk_gen (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .enable_i   (enable),
        .pdm_clk_o  (pdm_clk),
        .bit_tick_o (bit_tick)
    );

    logic [WIN_W-1:0]     win_q, win_d;
    ubin_t                acc_q, acc_d;
    pcm_t                 cur_q, cur_d;
    pcm_t                 buf_q, buf_d;
    logic                 buf_full_q, buf_full_d;
    logic                 pdm_data_q, pdm_data_d;
    logic                 underrun_q, underrun_d;
    logic                 xfer;
    logic                 boundary;

    assign pcm_ready = rst_n & enable & ~buf_full_q;
    assign xfer      = pcm_valid & pcm_ready;
    assign boundary  = bit_tick & (win_q == WIN_W'(OSR - 1));

    always_comb begin
        win_d      = win_q;
        acc_d      = acc_q;
        cur_d      = cur_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        pdm_data_d = pdm_data_q;
        underrun_d = 1'b0;
        if (!enable) begin
            win_d      = '0;
            acc_d      = '0;
            cur_d      = '0;
            buf_d      = '0;
            buf_full_d = 1'b0;
            pdm_data_d = 1'b0;
        end else begin
            if (xfer) begin
                buf_d      = pcm_t'(pcm_in);
                buf_full_d = 1'b1;
            end
            if (bit_tick) begin
                {pdm_data_d, acc_d} = {1'b0, acc_q} + {1'b0, to_offset_binary(cur_q)};
                if (boundary) begin
                    win_d = '0;
                    // A capture on this same clk only fills the buffer; it is
                    // consumed at the following boundary, never bypassed.
                    if (buf_full_q) begin
                        cur_d      = buf_q;
                        buf_full_d = 1'b0;
                    end else begin
                        underrun_d = 1'b1;
                    end
                end else begin
                    win_d = win_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q      <= '0;
            acc_q      <= '0;
            cur_q      <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            pdm_data_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            win_q      <= win_d;
            acc_q      <= acc_d;
            cur_q      <= cur_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            pdm_data_q <= pdm_data_d;
            underrun_q <= underrun_d;
        end
    end

    assign pdm_data = pdm_data_q;
    assign underrun = underrun_q;

endmodule
